// File: rtl/sr_driver_if.sv
// Button-side requests and SR-latch drive outputs of sr_driver.
interface sr_driver_if;
    logic set_req;
    logic rst_req;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_req,
        output rst_req,
        input  s,
        input  r,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_req,
        input  rst_req,
        output s,
        output r,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_driver.sv
// Debounced set/reset pulse driver for a downstream SR latch.
// Bit 0 of the request vectors is the set path, bit 1 the reset path.
module sr_driver #(
    parameter int DEBOUNCE = 4,
    parameter int PULSE    = 2,
    parameter int GUARD    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    sr_driver_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SET_P,
        ST_RST_P,
        ST_GUARD
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [7:0] PU_LAST = 8'(PULSE - 1);
    localparam logic [7:0] GU_LAST = 8'(GUARD - 1);
    localparam bit HAS_GUARD = (GUARD != 0);

    logic [1:0] w_req;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_db;
    logic [1:0] r_db_d;
    logic [1:0] w_ev;
    logic [1:0] r_pend;
    logic [7:0] r_dbcnt [2];

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_s;
    logic       r_r;
    logic       r_busy;
    logic       r_conflict;

    logic w_set_c;
    logic w_rst_c;
    logic w_pulse_end;
    logic w_guard_end;
    logic w_disp;

    assign w_req = {bus.rst_req, bus.set_req};
    assign w_ev  = r_db & ~r_db_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_db       <= '0;
            r_db_d     <= '0;
            r_dbcnt[0] <= '0;
            r_dbcnt[1] <= '0;
        end else begin
            r_sync1 <= w_req;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DB_LAST) begin
                    r_db[i]    <= ~r_db[i];
                    r_dbcnt[i] <= '0;
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_set_c = w_ev[0] | r_pend[0];
    assign w_rst_c = w_ev[1] | r_pend[1];

    assign w_pulse_end = (r_state == ST_SET_P || r_state == ST_RST_P)
                      && (r_cnt == PU_LAST);
    assign w_guard_end = (r_state == ST_GUARD) && (r_cnt == GU_LAST);

    // Dispatch also at phase end so queued work follows with no idle gap.
    assign w_disp = (r_state == ST_IDLE)
                 || (w_pulse_end && !HAS_GUARD)
                 || w_guard_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= 1'b0;
            if (w_disp) begin
                r_cnt  <= '0;
                r_pend <= '0;
                if (w_rst_c) begin
                    r_state    <= ST_RST_P;
                    r_s        <= 1'b0;
                    r_r        <= 1'b1;
                    r_busy     <= 1'b1;
                    r_conflict <= w_set_c;
                end else if (w_set_c) begin
                    r_state <= ST_SET_P;
                    r_s     <= 1'b1;
                    r_r     <= 1'b0;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            end else begin
                r_pend <= r_pend | w_ev;
                if (w_pulse_end) begin
                    r_state <= ST_GUARD;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.s        = r_s;
    assign bus.r        = r_r;
    assign bus.busy     = r_busy;
    assign bus.conflict = r_conflict;
endmodule
